line_clear_unit: RTL

//  Post-landing stage for the 12x12 falling-block board. When the piece-motion block

---
 rtl/tetris_pkg.sv | 39 +++
 rtl/line_score_lut.sv | 28 ++
 rtl/line_clear_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_pkg
//  Purpose  : Shared constants, types and helpers for the 12x12 falling-block
//             board. Board bit r*COLS+c is (row r, col c). Row 0 is the top.
//             Bit BOARD_W-1 is a spare bit that is carried along untouched.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int COLS    = 12;
    localparam int ROWS    = 12;
    localparam int BOARD_W = 145;
    localparam int SCORE_W = 16;

    typedef logic [BOARD_W-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } lc_state_t;

    // Points awarded for a pass, indexed by the number of rows cleared.
    localparam logic [SCORE_W-1:0] SCORE_0 = SCORE_W'(0);
    localparam logic [SCORE_W-1:0] SCORE_1 = SCORE_W'(40);
    localparam logic [SCORE_W-1:0] SCORE_2 = SCORE_W'(100);
    localparam logic [SCORE_W-1:0] SCORE_3 = SCORE_W'(300);
    localparam logic [SCORE_W-1:0] SCORE_4 = SCORE_W'(1200);

    // True when every cell of the given row is occupied.
    function automatic logic row_full(input board_t board, input logic [3:0] row);
        return &board[int'(row)*COLS +: COLS];
    endfunction

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/line_score_lut.sv
`default_nettype none
// ============================================================================
//  Module   : line_score_lut
//  Purpose  : Combinational points table for one clear pass.
//  Ports    : count  in  4        rows cleared in the pass (0..12)
//             points out SCORE_W  points to add to the running score
//  Revision : 1.0 - initial release
// ============================================================================
module line_score_lut
    import tetris_pkg::*;
(
    input  logic [3:0]         count,
    output logic [SCORE_W-1:0] points
);

    always_comb begin
        points = SCORE_0;
        case (count)
            4'd0:    points = SCORE_0;
            4'd1:    points = SCORE_1;
            4'd2:    points = SCORE_2;
            4'd3:    points = SCORE_3;
            default: points = SCORE_4;   // four or more rows
        endcase
    end

endmodule : line_score_lut
`default_nettype wire

// File: rtl/line_clear_unit.sv
`default_nettype none
// ============================================================================
//  Module   : line_clear_unit
//  Purpose  : Post-landing stage. Loads the merged background, scans rows from
//             the bottom up, removes each full row by dropping everything above
//             it by one row (one row per cycle), then reports the compacted
//             board, the number of rows removed, a saturating score and a
//             sticky game-over flag.
//  Ports    : clk            in   1        system clock
//             resetn         in   1        asynchronous active-low reset
//             start          in   1        pulse: board_in valid, begin a pass
//             board_in       in   BOARD_W  background with landed piece merged
//             board_out      out  BOARD_W  working / result board
//             busy           out  1        pass in progress (incl. done cycle)
//             done           out  1        pulse: results final for this pass
//             lines_cleared  out  4        rows removed in last pass
//             score          out  SCORE_W  cumulative saturating score
//             game_over      out  1        sticky: row 0 occupied after a pass
//  Revision : 1.0 - initial release
// ============================================================================
module line_clear_unit
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    output logic [BOARD_W-1:0] board_out,
    output logic               busy,
    output logic               done,
    output logic [3:0]         lines_cleared,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    lc_state_t          state;
    lc_state_t          state_nx;
    board_t             board_reg;
    board_t             shifted;
    logic [3:0]         row_ptr;
    logic [3:0]         line_cnt;
    logic               cur_full;
    logic               accept;
    logic [SCORE_W-1:0] points;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign board_out = board_reg;
    assign cur_full  = row_full(board_reg, row_ptr);

    // busy stays high through the done cycle, so a start there is dropped too.
    assign accept = start && (state == IDLE) && !busy;

    // Drop rows 1..row_ptr by one; rows below row_ptr keep their contents.
    assign shifted[BOARD_W-1] = board_reg[BOARD_W-1];
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            if (r == 0) begin : g_top
                assign shifted[0 +: COLS] = '0;
            end else begin : g_body
                assign shifted[r*COLS +: COLS] = (4'(r) <= row_ptr)
                                               ? board_reg[(r-1)*COLS +: COLS]
                                               : board_reg[r*COLS +: COLS];
            end
        end
    endgenerate

    line_score_lut u_lut (
        .count  (line_cnt),
        .points (points)
    );

    assign score_sum = {1'b0, score} + {1'b0, points};
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK: begin
                if (cur_full)           state_nx = SHIFT;   // re-check same row after the drop
                else if (row_ptr == '0) state_nx = DONE;
            end
            SHIFT:   state_nx = CHECK;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            board_reg     <= '0;
            row_ptr       <= 4'(ROWS-1);
            line_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            score         <= '0;
            game_over     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        board_reg <= board_in;
                        row_ptr   <= 4'(ROWS-1);
                        line_cnt  <= '0;
                        busy      <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!cur_full && row_ptr != '0) begin
                        row_ptr <= row_ptr - 4'd1;
                    end
                end
                SHIFT: begin
                    board_reg <= shifted;
                    line_cnt  <= line_cnt + 4'd1;
                end
                DONE: begin
                    lines_cleared <= line_cnt;
                    score         <= score_sat;
                    game_over     <= game_over | (|board_reg[COLS-1:0]);
                end
                default: ;
            endcase
        end
    end

endmodule : line_clear_unit
`default_nettype wire
